// File: rtl/rtx_fb_writer_pkg.sv
// Shared types and sizing helpers for the ray-tracer framebuffer writer.
// Holds the pixel format, the writer FSM states and the framebuffer address width.
package rtx_fb_writer_pkg;

  localparam int DEFAULT_WIDTH  = 1280;
  localparam int DEFAULT_HEIGHT = 720;

  function automatic int fb_addr_w_f(input int w, input int h);
    return $clog2(w * h);
  endfunction

  localparam int FB_ADDR_W = fb_addr_w_f(DEFAULT_WIDTH, DEFAULT_HEIGHT);

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic {
    ST_RUN,
    ST_CLEAR
  } wr_state_e;

endpackage

// File: rtl/rtx_fb_writer_fifo.sv
// Synchronous pixel FIFO of {addr,data} entries with full/empty flags.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rtx_fb_writer.sv
// Collects ray-tracer pixels into a FIFO and writes them to the framebuffer,
// with a clear mode that sweeps the whole framebuffer to zero.
module rtx_fb_writer
  import rtx_fb_writer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int HEIGHT     = DEFAULT_HEIGHT,
  parameter int FIFO_DEPTH = 8,
  localparam int ADDR_W    = fb_addr_w_f(WIDTH, HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       rtx_pixel,
  input  logic [10:0]       pixel_h,
  input  logic [9:0]        pixel_v,
  input  logic              ray_done,
  input  logic              clear_req,
  input  logic              fb_ready,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_data,
  output logic              frame_done,
  output logic              clear_done,
  output logic [15:0]       frame_count,
  output logic              overflow,
  output logic              oob
);

  localparam logic [10:0]       H_LIM     = 11'(WIDTH);
  localparam logic [9:0]        V_LIM     = 10'(HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  wr_state_e           state, state_next;
  logic                s1_valid;
  logic                s1_oob;
  logic [ADDR_W-1:0]   s1_addr;
  rgb565_t             s1_data;
  logic [ADDR_W-1:0]   sweep;
  logic                push, pop, full, empty;
  logic [ADDR_W+15:0]  head;
  logic [ADDR_W-1:0]   head_addr;
  logic [15:0]         head_data;
  logic                sweep_last;

  assign push       = s1_valid && !s1_oob;
  assign head_addr  = head[ADDR_W+15:16];
  assign head_data  = head[15:0];
  assign sweep_last = (state == ST_CLEAR) && fb_ready && (sweep == LAST_ADDR);

  // Address is formed at 32 bits so in-range coordinates never truncate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= ray_done;
      s1_oob   <= (pixel_h >= H_LIM) || (pixel_v >= V_LIM);
      s1_addr  <= ADDR_W'(32'(pixel_v) * 32'(WIDTH) + 32'(pixel_h));
      s1_data  <= rtx_pixel;
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (ADDR_W + 16)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({s1_addr, s1_data}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_data    = '0;
    pop        = 1'b0;
    case (state)
      ST_RUN: begin
        fb_we = !empty;
        if (!empty) begin
          fb_addr = head_addr;
          fb_data = head_data;
        end
        pop = !empty && fb_ready;
        if (clear_req) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        fb_we   = 1'b1;
        fb_addr = sweep;
        if (sweep_last) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Completion pulses, frame counter, sweep counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep       <= '0;
      frame_done  <= 1'b0;
      clear_done  <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
      oob         <= 1'b0;
    end else begin
      frame_done <= pop && (head_addr == LAST_ADDR);
      clear_done <= sweep_last;
      if (pop && (head_addr == LAST_ADDR)) frame_count <= frame_count + 16'd1;
      if (state == ST_CLEAR && fb_ready) sweep <= sweep_last ? '0 : sweep + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      if (s1_valid && s1_oob)   oob      <= 1'b1;
    end
  end

endmodule
